// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers, granting bursts of up to MAX_BURST words.
// Latency: req->gnt 1 cycle, first write in the grant cycle; fifo_wr_ready low stalls the owner indefinitely.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        ack,
  output logic [NREQ-1:0]        gnt,
  output logic                   fifo_wr_en,
  output logic [DATA_W-1:0]      fifo_wr_data,
  input  logic                   fifo_wr_ready,
  output logic                   busy
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  typedef enum logic {S_IDLE = 1'b0, S_OWN = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [NREQ-1:0]  r_gnt, w_gnt_nxt;
  logic [PTR_W-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [CNT_W-1:0] r_beat_cnt, w_beat_cnt_nxt;

  logic [PTR_W-1:0]  w_owner;
  logic [PTR_W-1:0]  w_owner_inc;
  logic [DATA_W-1:0] w_owner_data;
  logic              w_owner_req;
  logic [PTR_W-1:0]  w_winner;
  logic              w_winner_vld;
  logic [PTR_W:0]    w_idx;
  logic              w_xfer;
  logic              w_release;

  always_comb begin
    w_owner      = '0;
    w_owner_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_gnt[i]) begin
        w_owner      = PTR_W'(i);
        w_owner_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_owner_req = |(req & r_gnt);
  assign w_owner_inc = (w_owner == PTR_W'(NREQ - 1)) ? '0 : w_owner + PTR_W'(1);
  assign w_xfer      = (r_state == S_OWN) && w_owner_req && fifo_wr_ready;
  assign w_release   = (w_xfer && (r_beat_cnt == LAST_BEAT)) || !w_owner_req;

  // Scan from the highest offset down so the requester closest to r_rr_ptr wins.
  always_comb begin
    w_winner     = '0;
    w_winner_vld = 1'b0;
    w_idx        = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
      if (w_idx >= (PTR_W+1)'(NREQ)) w_idx = w_idx - (PTR_W+1)'(NREQ);
      if (req[w_idx[PTR_W-1:0]]) begin
        w_winner     = w_idx[PTR_W-1:0];
        w_winner_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_gnt      <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  // Release always lands in IDLE, which forces the one-cycle bubble before the next grant.
  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_beat_cnt_nxt = r_beat_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_winner_vld) begin
          w_state_nxt    = S_OWN;
          w_gnt_nxt      = NREQ'(1) << w_winner;
          w_beat_cnt_nxt = '0;
        end
      end
      S_OWN: begin
        if (w_release) begin
          w_state_nxt    = S_IDLE;
          w_gnt_nxt      = '0;
          w_beat_cnt_nxt = '0;
          w_rr_ptr_nxt   = w_owner_inc;
        end else if (w_xfer) begin
          w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    gnt          = r_gnt;
    busy         = (r_state == S_OWN);
    fifo_wr_en   = w_xfer;
    fifo_wr_data = w_owner_data;
    ack          = w_xfer ? r_gnt : '0;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed-vector bench for fifo_wr_arbiter (NREQ=4, DATA_W=8, MAX_BURST=4).
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [3:0]  gnt;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_wr_arbiter #(.NREQ(4), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk(clk), .reset(rst_n), .req(req), .req_data(req_data), .ack(ack), .gnt(gnt),
    .fifo_wr_en(wr_en), .fifo_wr_data(wr_data), .fifo_wr_ready(wr_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Returns on a falling edge with reset just released and no requests.
  task automatic do_reset();
    rst_n    = 1'b0;
    req      = '0;
    wr_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_gnt, owner, pos, words, acks0, w0, w2;
    logic rdy;

    // 1: reset values, then a single word from requester 0
    rst_n = 1'b0; req = '0; req_data = '0; wr_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt",  32'(gnt),   0);
    chk("rst_wren", 32'(wr_en), 0);
    chk("rst_ack",  32'(ack),   0);
    chk("rst_busy", 32'(busy),  0);
    rst_n = 1'b1; req = 4'b0001; req_data[7:0] = 8'd10;
    @(negedge clk); #1;
    chk("t1_gnt",  32'(gnt),     32'h1);
    chk("t1_wren", 32'(wr_en),   1);
    chk("t1_data", 32'(wr_data), 10);
    chk("t1_ack",  32'(ack),     32'h1);
    chk("t1_busy", 32'(busy),    1);

    // 2: all requesting, one full round of 4-word bursts plus bubbles
    do_reset();
    req = 4'b1111; req_data = 32'hA3A2A1A0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      owner   = c / 5;
      pos     = c % 5;
      exp_gnt = (pos < 4) ? (1 << owner) : 0;
      chk("t2_gnt", 32'(gnt), exp_gnt);
      chk("t2_wr",  {23'd0, wr_en, wr_data}, (pos < 4) ? (32'h100 | (32'hA0 + owner)) : 0);
      chk("t2_ack", 32'(ack), exp_gnt);
    end
    @(negedge clk); #1;
    chk("t2_wrap_gnt", 32'(gnt), 32'h1);

    // 3: owner 2 stalls for 3 cycles after its first word
    do_reset();
    req = 4'b0100; req_data = 32'h00330000;
    @(negedge clk); #1;
    chk("t3_gnt",  32'(gnt),   32'h4);
    chk("t3_wren", 32'(wr_en), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); wr_ready = 1'b0; #1;
      chk("t3_stall_wren", 32'(wr_en), 0);
      chk("t3_stall_ack",  32'(ack),   0);
      chk("t3_stall_gnt",  32'(gnt),   32'h4);
    end
    words = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); wr_ready = 1'b1; #1;
      if (ack[2]) words++;
      chk("t3_resume_data", 32'(wr_data), 32'h33);
    end
    chk("t3_words", words, 3);
    @(negedge clk); #1;
    chk("t3_release_gnt", 32'(gnt), 0);

    // 4: owner 0 drops its request after 2 words while requester 1 waits
    do_reset();
    req = 4'b0011; req_data = 32'h00001100; acks0 = 0;
    @(negedge clk); #1;
    chk("t4_gnt0", 32'(gnt), 32'h1);
    if (ack[0]) acks0++;
    @(negedge clk); #1;
    if (ack[0]) acks0++;
    @(negedge clk); req = 4'b0010; #1;
    if (ack[0]) acks0++;
    chk("t4_drop_wren", 32'(wr_en), 0);
    @(negedge clk); #1;
    chk("t4_bubble_gnt", 32'(gnt), 0);
    chk("t4_rr_ptr", 32'(dut.r_rr_ptr), 1);
    @(negedge clk); #1;
    chk("t4_gnt1", 32'(gnt), 32'h2);
    chk("t4_acks0", acks0, 2);

    // 5: asynchronous reset during owner 1's second word
    do_reset();
    req = 4'b0010; req_data = 32'h00005500;
    @(negedge clk); #1;
    chk("t5_gnt1", 32'(gnt), 32'h2);
    @(negedge clk); #1;
    chk("t5_word2_wren", 32'(wr_en), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_async_gnt",  32'(gnt),   0);
    chk("t5_async_wren", 32'(wr_en), 0);
    chk("t5_async_busy", 32'(busy),  0);
    @(negedge clk); rst_n = 1'b1; req = 4'b1000; #1;
    chk("t5_rr_ptr", 32'(dut.r_rr_ptr), 0);
    @(negedge clk); #1;
    chk("t5_gnt3", 32'(gnt), 32'h8);

    // 6: requesters 0 and 2 with wr_ready toggling every cycle
    do_reset();
    req_data = 32'h00CC00AA; w0 = 0; w2 = 0;
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      rdy      = (k % 2 == 0);
      wr_ready = rdy;
      req      = 4'b0101;
      #1;
      if (k == 0 || k == 9 || k == 17) exp_gnt = 0;
      else if (k >= 10 && k <= 16)     exp_gnt = 32'h4;
      else                             exp_gnt = 32'h1;
      chk("t6_gnt",  32'(gnt),   exp_gnt);
      chk("t6_wren", 32'(wr_en), (rdy && exp_gnt != 0) ? 1 : 0);
      if (k < 18 && ack[0]) w0++;
      if (k < 18 && ack[2]) w2++;
    end
    chk("t6_words0", w0, 4);
    chk("t6_words2", w2, 4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
